// File: rtl/router_pkg.sv
// router_pkg: shared types and constants for the 1X3 router control path.
//   NUM_PORTS    - number of output FIFOs (width of fifo_empty / soft_reset)
//   ADDR_W       - width of the header address field
//   INVALID_ADDR - header address that never selects a port
//   state_t      - controller state encoding
package router_pkg;

    localparam int NUM_PORTS = 3;
    localparam int ADDR_W = 2;
    localparam logic [ADDR_W-1:0] INVALID_ADDR = 2'b11;

    typedef enum logic [2:0] {
        DECODE_ADDRESS,
        LOAD_FIRST_DATA,
        LOAD_DATA,
        WAIT_TILL_EMPTY,
        FIFO_FULL_STATE,
        LOAD_AFTER_FULL,
        LOAD_PARITY,
        CHECK_PARITY_ERROR
    } state_t;

endpackage

// File: rtl/router_ctrl_fsm.sv
// router_ctrl_fsm: packet sequencing controller for the 1X3 router.
//   clock, resetn         - clock and synchronous active-low reset
//   pkt_valid, data_in    - source handshake and header address field
//   fifo_full, fifo_empty - selected-FIFO full flag, per-port empty flags
//   soft_reset            - per-port timeout reset
//   parity_done, low_pkt_valid - status from the register block
//   detect_add..rst_int_reg    - one-per-state strobes to the register block
//   write_enb_reg, busy   - FIFO write enable and source hold
//   dest_addr             - latched destination port
module router_ctrl_fsm
    import router_pkg::*;
(
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 pkt_valid,
    input  logic [ADDR_W-1:0]    data_in,
    input  logic                 fifo_full,
    input  logic [NUM_PORTS-1:0] fifo_empty,
    input  logic [NUM_PORTS-1:0] soft_reset,
    input  logic                 parity_done,
    input  logic                 low_pkt_valid,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 rst_int_reg,
    output logic                 write_enb_reg,
    output logic                 busy,
    output logic [ADDR_W-1:0]    dest_addr
);

    state_t state, next_state;
    logic   addr_ok;

    // widened by one bit so addresses at or above NUM_PORTS compare correctly
    assign addr_ok = pkt_valid && ({1'b0, data_in} < (ADDR_W+1)'(NUM_PORTS));

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state     <= DECODE_ADDRESS;
            dest_addr <= '0;
        end else begin
            state <= next_state;
            if (state == DECODE_ADDRESS && addr_ok)
                dest_addr <= data_in;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            DECODE_ADDRESS:     if (addr_ok) next_state = fifo_empty[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            WAIT_TILL_EMPTY:    if (fifo_empty[dest_addr]) next_state = LOAD_FIRST_DATA;
            LOAD_FIRST_DATA:    next_state = LOAD_DATA;
            LOAD_DATA:          next_state = fifo_full ? FIFO_FULL_STATE : !pkt_valid ? LOAD_PARITY : LOAD_DATA;
            FIFO_FULL_STATE:    if (!fifo_full) next_state = LOAD_AFTER_FULL;
            LOAD_AFTER_FULL:    next_state = parity_done ? DECODE_ADDRESS : low_pkt_valid ? LOAD_PARITY : LOAD_DATA;
            LOAD_PARITY:        next_state = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            default:            next_state = DECODE_ADDRESS;
        endcase
        // a timeout on the selected port abandons the packet from any active state
        if (state != DECODE_ADDRESS && soft_reset[dest_addr])
            next_state = DECODE_ADDRESS;
    end

    always_comb begin
        detect_add    = state == DECODE_ADDRESS;
        lfd_state     = state == LOAD_FIRST_DATA;
        ld_state      = state == LOAD_DATA;
        laf_state     = state == LOAD_AFTER_FULL;
        full_state    = state == FIFO_FULL_STATE;
        rst_int_reg   = state == CHECK_PARITY_ERROR;
        write_enb_reg = lfd_state || ld_state || laf_state || state == LOAD_PARITY;
        busy          = !(detect_add || ld_state);
    end

endmodule
